pingpong_buf_ctrl: RTL and testbench

- Sequencing controller for the double (ping-pong) data buffer that feeds the convolution datapath.
- Accepts a valid/ready input stream and turns it into write strobes, addresses and a bank select for the buffer.
- Tracks the fill state of both banks. Once a bank is full, it generates the read-enable and base-address sequence for the consumer on that bank while the writer fills the other bank.
- Sits between the data loader and the buffer's wr_*/rd_en/rd_addr inputs.

---
 rtl/pingpong_buf_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pingpong_buf_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buf_ctrl.sv
// rtl/pingpong_buf_ctrl.sv - ping-pong buffer sequencing controller
// Turns a valid/ready word stream into bank writes and drains each full bank as a read-beat sequence.
module pingpong_buf_ctrl #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_BEATS   = 28,
  parameter int RD_STEP    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  wr_bank,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_base,
  output logic                  rd_bank,
  input  logic                  rd_accept,
  output logic                  rd_last,
  output logic                  bank_done,
  output logic [1:0]            bank_full
);

  localparam int WCNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RCNT_W = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
  localparam logic [WCNT_W-1:0]     WCNT_MAX  = WCNT_W'(DEPTH - 1);
  localparam logic [RCNT_W-1:0]     RCNT_MAX  = RCNT_W'(RD_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(RD_STEP);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
  typedef enum logic {R_IDLE, R_RUN} rd_st_e;

  bank_st_e               bank_st_q [2];
  bank_st_e               bank_st_d [2];
  rd_st_e                 rstate_q, rstate_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]       wr_data_q, wr_data_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  rd_base_q, rd_base_d;
  logic                   rd_last_q, rd_last_d;
  logic                   bank_done_q, bank_done_d;
  logic                   wr_open;
  logic                   hs;

  // The writer may only target a bank the reader has released or is still filling.
  assign wr_open = (bank_st_q[wr_ptr_q] == B_EMPTY) || (bank_st_q[wr_ptr_q] == B_FILLING);
  assign s_ready = ~rst & wr_open;
  assign hs      = s_valid & s_ready;

  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    rstate_d     = rstate_q;
    wr_ptr_d     = wr_ptr_q;
    wcnt_d       = wcnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    rcnt_d       = rcnt_q;
    rd_en_d      = rd_en_q;
    rd_base_d    = rd_base_q;
    rd_last_d    = rd_last_q;
    bank_done_d  = 1'b0;

    if (hs) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ADDR_WIDTH'(wcnt_q);
      wr_data_d = s_data;
      wr_bank_d = wr_ptr_q;
      if (wcnt_q == WCNT_MAX) begin
        wcnt_d              = '0;
        bank_st_d[wr_ptr_q] = B_FULL;
        wr_ptr_d            = ~wr_ptr_q;
      end else begin
        wcnt_d              = wcnt_q + WCNT_W'(1);
        bank_st_d[wr_ptr_q] = B_FILLING;
      end
    end

    // Writer and reader always sit on different banks here, so both updates can land together.
    case (rstate_q)
      R_IDLE: begin
        if (bank_st_q[rd_bank_q] == B_FULL) begin
          rstate_d               = R_RUN;
          bank_st_d[rd_bank_q]   = B_DRAINING;
          rcnt_d                 = '0;
          rd_base_d              = '0;
          rd_en_d                = 1'b1;
          rd_last_d              = (RD_BEATS == 1);
        end
      end
      R_RUN: begin
        if (rd_accept) begin
          if (rcnt_q == RCNT_MAX) begin
            rstate_d             = R_IDLE;
            bank_st_d[rd_bank_q] = B_EMPTY;
            bank_done_d          = 1'b1;
            rd_bank_d            = ~rd_bank_q;
            rcnt_d               = '0;
            rd_en_d              = 1'b0;
            rd_base_d            = '0;
            rd_last_d            = 1'b0;
          end else begin
            rcnt_d               = rcnt_q + RCNT_W'(1);
            rd_base_d            = rd_base_q + BASE_STEP;
            rd_last_d            = ((rcnt_q + RCNT_W'(1)) == RCNT_MAX);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= B_EMPTY;
      bank_st_q[1] <= B_EMPTY;
      rstate_q     <= R_IDLE;
      wr_ptr_q     <= 1'b0;
      wcnt_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rcnt_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_base_q    <= '0;
      rd_last_q    <= 1'b0;
      bank_done_q  <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      rstate_q     <= rstate_d;
      wr_ptr_q     <= wr_ptr_d;
      wcnt_q       <= wcnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rcnt_q       <= rcnt_d;
      rd_en_q      <= rd_en_d;
      rd_base_q    <= rd_base_d;
      rd_last_q    <= rd_last_d;
      bank_done_q  <= bank_done_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_bank      = wr_bank_q;
  assign rd_en        = rd_en_q;
  assign rd_base      = rd_base_q;
  assign rd_bank      = rd_bank_q;
  assign rd_last      = rd_last_q;
  assign bank_done    = bank_done_q;
  assign bank_full[0] = (bank_st_q[0] == B_FULL) || (bank_st_q[0] == B_DRAINING);
  assign bank_full[1] = (bank_st_q[1] == B_FULL) || (bank_st_q[1] == B_DRAINING);

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// tb/tb_pingpong_buf_ctrl.sv - directed self-checking bench for pingpong_buf_ctrl
module tb_pingpong_buf_ctrl;

  localparam int DEPTH    = 4;
  localparam int WIDTH    = 8;
  localparam int AW       = 16;
  localparam int RD_BEATS = 3;
  localparam int RD_STEP  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_bank;
  logic          rd_en;
  logic [AW-1:0] rd_base;
  logic          rd_bank;
  logic          rd_accept;
  logic          rd_last;
  logic          bank_done;
  logic [1:0]    bank_full;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent, n_wr, n_rd, n_done;
  logic       hs;
  logic [7:0] mem [2][4];

  pingpong_buf_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .RD_BEATS(RD_BEATS), .RD_STEP(RD_STEP)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_base(rd_base), .rd_bank(rd_bank), .rd_accept(rd_accept),
    .rd_last(rd_last), .bank_done(bank_done), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; rd_accept = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with s_valid asserted
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; rd_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("rst_s_ready", 32'(s_ready), 0);
      check_eq("rst_wr_en", 32'(wr_en), 0);
      check_eq("rst_rd_en", 32'(rd_en), 0);
      check_eq("rst_bank_full", 32'(bank_full), 0);
    end
    check_eq("rst_rd_last", 32'(rd_last), 0);
    check_eq("rst_bank_done", 32'(bank_done), 0);
    check_eq("rst_wr_addr", 32'(wr_addr), 0);
    check_eq("rst_rd_base", 32'(rd_base), 0);
    check_eq("rst_wr_bank", 32'(wr_bank), 0);
    check_eq("rst_rd_bank", 32'(rd_bank), 0);

    // Single fill of bank 0 then drain
    rst = 1'b0; s_valid = 1'b1; s_data = 8'd1; rd_accept = 1'b1;
    settle();
    check_eq("fill_s_ready", 32'(s_ready), 1);
    for (int k = 0; k < 4; k++) begin
      s_data = 8'(2 * k + 1);
      cyc();
      check_eq("fill_wr_en", 32'(wr_en), 1);
      check_eq("fill_wr_addr", 32'(wr_addr), k);
      check_eq("fill_wr_data", 32'(wr_data), 2 * k + 1);
      check_eq("fill_wr_bank", 32'(wr_bank), 0);
      check_eq("fill_rd_en", 32'(rd_en), 0);
    end
    check_eq("fill_bank_full", 32'(bank_full), 1);
    s_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      cyc();
      check_eq("drain_rd_en", 32'(rd_en), 1);
      check_eq("drain_rd_base", 32'(rd_base), b);
      check_eq("drain_rd_bank", 32'(rd_bank), 0);
      check_eq("drain_rd_last", 32'(rd_last), (b == 2) ? 1 : 0);
      check_eq("drain_wr_en", 32'(wr_en), 0);
      check_eq("drain_bank_full", 32'(bank_full), 1);
    end
    cyc();
    check_eq("rel_rd_en", 32'(rd_en), 0);
    check_eq("rel_bank_done", 32'(bank_done), 1);
    check_eq("rel_bank_full", 32'(bank_full), 0);
    check_eq("rel_rd_bank", 32'(rd_bank), 1);
    cyc();
    check_eq("rel_done_pulse", 32'(bank_done), 0);

    // Back-pressure: both banks filled while the reader is stalled
    do_reset();
    s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_data = 8'(16 + k);
      cyc();
      check_eq("bp_wr_en", 32'(wr_en), 1);
      check_eq("bp_wr_addr", 32'(wr_addr), k % 4);
      check_eq("bp_wr_bank", 32'(wr_bank), k / 4);
      check_eq("bp_wr_data", 32'(wr_data), 16 + k);
    end
    s_data = 8'h99;
    settle();
    check_eq("bp_s_ready_low", 32'(s_ready), 0);
    check_eq("bp_bank_full", 32'(bank_full), 3);
    check_eq("bp_rd_en", 32'(rd_en), 1);
    check_eq("bp_rd_bank", 32'(rd_bank), 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_eq("bp_hold_wr_en", 32'(wr_en), 0);
      check_eq("bp_hold_rd_base", 32'(rd_base), 0);
      check_eq("bp_hold_s_ready", 32'(s_ready), 0);
    end
    rd_accept = 1'b1;
    cyc();
    check_eq("bp_rd_base1", 32'(rd_base), 1);
    cyc();
    check_eq("bp_rd_base2", 32'(rd_base), 2);
    check_eq("bp_rd_last", 32'(rd_last), 1);
    check_eq("bp_s_ready_still_low", 32'(s_ready), 0);
    cyc();
    check_eq("bp_bank_done", 32'(bank_done), 1);
    check_eq("bp_s_ready_back", 32'(s_ready), 1);
    check_eq("bp_rd_gap", 32'(rd_en), 0);
    check_eq("bp_bank_full_10", 32'(bank_full), 2);
    s_valid = 1'b0;
    cyc();
    check_eq("bp_b1_rd_en", 32'(rd_en), 1);
    check_eq("bp_b1_rd_bank", 32'(rd_bank), 1);
    check_eq("bp_b1_rd_base", 32'(rd_base), 0);
    check_eq("bp_b1_wr_en", 32'(wr_en), 0);
    cyc(); cyc(); cyc();
    check_eq("bp_b1_done", 32'(bank_done), 1);
    check_eq("bp_b1_bank_full", 32'(bank_full), 0);
    check_eq("bp_b1_rd_bank_next", 32'(rd_bank), 0);

    // Read stall on beat 1
    do_reset();
    rd_accept = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = 8'(32 + k);
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    check_eq("st_rd_base0", 32'(rd_base), 0);
    cyc();
    check_eq("st_rd_base1", 32'(rd_base), 1);
    rd_accept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("st_hold_rd_en", 32'(rd_en), 1);
      check_eq("st_hold_rd_base", 32'(rd_base), 1);
      check_eq("st_hold_rd_last", 32'(rd_last), 0);
    end
    rd_accept = 1'b1;
    cyc();
    check_eq("st_rd_base2", 32'(rd_base), 2);
    check_eq("st_rd_last", 32'(rd_last), 1);
    cyc();
    check_eq("st_done", 32'(bank_done), 1);
    check_eq("st_rd_en_off", 32'(rd_en), 0);

    // Overlap: continuous stream of 16 words across four bank fills
    do_reset();
    rd_accept = 1'b1;
    n_sent = 0; n_wr = 0; n_rd = 0; n_done = 0;
    for (int c = 0; c < 24; c++) begin
      s_valid = (n_sent < 16);
      s_data  = 8'(8'h40 + n_sent);
      settle();
      if (s_valid) check_eq("ovl_s_ready", 32'(s_ready), 1);
      hs = s_valid;
      cyc();
      if (hs) n_sent++;
      if (bank_done) n_done++;
      if (wr_en) begin
        check_eq("ovl_wr_bank", 32'(wr_bank), (n_wr / 4) % 2);
        check_eq("ovl_wr_addr", 32'(wr_addr), n_wr % 4);
        check_eq("ovl_wr_data", 32'(wr_data), 8'h40 + n_wr);
        mem[wr_bank][wr_addr[1:0]] = wr_data;
        n_wr++;
      end
      if (rd_en && rd_accept) begin
        check_eq("ovl_rd_bank", 32'(rd_bank), (n_rd / 3) % 2);
        check_eq("ovl_rd_data", 32'(mem[rd_bank][rd_base[1:0]]), 8'h40 + 4 * (n_rd / 3) + (n_rd % 3));
        n_rd++;
      end
    end
    check_eq("ovl_wr_count", 32'(n_wr), 16);
    check_eq("ovl_rd_count", 32'(n_rd), 12);
    check_eq("ovl_done_count", 32'(n_done), 4);
    check_eq("ovl_bank_full_end", 32'(bank_full), 0);

    // Mid-operation reset during a fill and during a drain
    do_reset();
    s_valid = 1'b1; rd_accept = 1'b1;
    s_data = 8'h71; cyc();
    s_data = 8'h72; cyc();
    check_eq("mr_wr_addr1", 32'(wr_addr), 1);
    rst = 1'b1; s_data = 8'h73;
    settle();
    check_eq("mr_s_ready_rst", 32'(s_ready), 0);
    cyc();
    check_eq("mr_wr_en", 32'(wr_en), 0);
    check_eq("mr_wr_addr0", 32'(wr_addr), 0);
    check_eq("mr_wr_data0", 32'(wr_data), 0);
    check_eq("mr_bank_full", 32'(bank_full), 0);
    rst = 1'b0;
    s_data = 8'h81;
    cyc();
    check_eq("mr_restart_wr_en", 32'(wr_en), 1);
    check_eq("mr_restart_addr", 32'(wr_addr), 0);
    check_eq("mr_restart_bank", 32'(wr_bank), 0);
    check_eq("mr_restart_data", 32'(wr_data), 8'h81);
    for (int k = 1; k < 4; k++) begin
      s_data = 8'(8'h81 + k);
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    check_eq("mr_drain_rd_en", 32'(rd_en), 1);
    cyc();
    check_eq("mr_drain_rd_base", 32'(rd_base), 1);
    rst = 1'b1;
    cyc();
    check_eq("mr2_rd_en", 32'(rd_en), 0);
    check_eq("mr2_rd_base", 32'(rd_base), 0);
    check_eq("mr2_rd_last", 32'(rd_last), 0);
    check_eq("mr2_bank_done", 32'(bank_done), 0);
    check_eq("mr2_bank_full", 32'(bank_full), 0);
    rst = 1'b0; s_valid = 1'b1; s_data = 8'h91;
    cyc();
    check_eq("mr2_restart_wr_en", 32'(wr_en), 1);
    check_eq("mr2_restart_addr", 32'(wr_addr), 0);
    check_eq("mr2_restart_bank", 32'(wr_bank), 0);
    check_eq("mr2_restart_data", 32'(wr_data), 8'h91);
    check_eq("mr2_rd_bank", 32'(rd_bank), 0);
    s_valid = 1'b0;
    cyc();
    check_eq("mr2_no_read", 32'(rd_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
